load_store_unit: RTL and testbench

Initiator side of the data-memory interface. It sits between the execute stage and `DataMemory`. It accepts one RV64 load or store request at a time and drives the memory's doubleword read/write port. Sub-word stores are built with read-modify-write, and load results are extracted and sign- or zero-extended. Misaligned, out-of-range and reserved-index accesses are rejected without touching memory.

---
 rtl/load_store_if.sv | 37 +++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// The slave modport is the unit itself. The master modport is its
// environment: the execute stage driving requests plus the memory
// returning combinational read data.
interface load_store_if #(
    parameter int BITSIZE = 64,
    parameter int REGSIZE = 64
);
    localparam int IW = $clog2(REGSIZE);

    logic               ReqValid;
    logic               ReqReady;
    logic               ReqWrite;
    logic [2:0]         ReqFunct3;
    logic [63:0]        ReqAddress;
    logic [BITSIZE-1:0] ReqStoreData;
    logic               RespValid;
    logic [BITSIZE-1:0] RespData;
    logic               RespError;
    logic [IW-1:0]      MemoryAddress;
    logic               MemReadEnable;
    logic               MemWriteEnable;
    logic [BITSIZE-1:0] MemWriteData;
    logic [BITSIZE-1:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqFunct3, ReqAddress, ReqStoreData, MemReadData,
        output ReqReady, RespValid, RespData, RespError,
               MemoryAddress, MemReadEnable, MemWriteEnable, MemWriteData
    );

    modport master (
        output ReqValid, ReqWrite, ReqFunct3, ReqAddress, ReqStoreData, MemReadData,
        input  ReqReady, RespValid, RespData, RespError,
               MemoryAddress, MemReadEnable, MemWriteEnable, MemWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store initiator for a doubleword-wide data memory.
// One request at a time: sub-word stores use read-modify-write, loads are
// extracted from the read doubleword and sign/zero-extended. Illegal,
// misaligned, out-of-range and reserved-index requests are answered with
// an error without touching memory.
module load_store_unit #(
    parameter int BITSIZE = 64,
    parameter int REGSIZE = 64
) (
    input  logic          clk,
    input  logic          rst,
    load_store_if.slave   bus
);
    localparam int IW = $clog2(REGSIZE);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IW+2:0]       r_addr;
    logic [2:0]          r_funct3;
    logic                r_write;
    logic [BITSIZE-1:0]  r_wdata;
    logic                r_err;
    logic [BITSIZE-1:0]  r_rdbuf;

    logic                w_accept;
    logic                w_req_err;
    logic [IW-1:0]       w_idx;
    logic [2:0]          w_off;

    logic                w_ready;
    logic                w_resp_valid;
    logic [BITSIZE-1:0]  w_resp_data;
    logic                w_resp_error;
    logic [IW-1:0]       w_mem_addr;
    logic                w_mem_re;
    logic                w_mem_we;
    logic [BITSIZE-1:0]  w_mem_wdata;

    // Request screening: funct3 legality, natural alignment, address range
    // and the reserved indices (top doubleword for loads, index 0 for stores).
    function automatic logic f_req_error(input logic wr, input logic [2:0] f3,
                                         input logic [63:0] addr);
        logic          illegal;
        logic          misaligned;
        logic          out_of_range;
        logic          reserved;
        logic [IW-1:0] idx;
        illegal = wr ? f3[2] : (f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            2'b11:   misaligned = (addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        out_of_range = (addr[63:IW+3] != '0);
        idx = addr[IW+2:3];
        reserved = wr ? (idx == '0) : (idx == IW'(REGSIZE - 1));
        return illegal | misaligned | out_of_range | reserved;
    endfunction

    // Shift the addressed bytes down and extend them to the full width.
    function automatic logic [BITSIZE-1:0] f_extract(input logic [BITSIZE-1:0] rd,
                                                     input logic [2:0] off,
                                                     input logic [2:0] f3);
        logic [BITSIZE-1:0] sh;
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        logic signed [31:0] s32;
        logic [BITSIZE-1:0] res;
        sh  = rd >> {off, 3'b000};
        s8  = $signed(sh[7:0]);
        s16 = $signed(sh[15:0]);
        s32 = $signed(sh[31:0]);
        case (f3[1:0])
            2'b00:   res = f3[2] ? BITSIZE'(sh[7:0])  : BITSIZE'(s8);
            2'b01:   res = f3[2] ? BITSIZE'(sh[15:0]) : BITSIZE'(s16);
            2'b10:   res = f3[2] ? BITSIZE'(sh[31:0]) : BITSIZE'(s32);
            default: res = sh;
        endcase
        return res;
    endfunction

    // Overlay the low 1/2/4 store bytes onto the read doubleword at the offset.
    function automatic logic [BITSIZE-1:0] f_merge(input logic [BITSIZE-1:0] rd,
                                                   input logic [BITSIZE-1:0] wd,
                                                   input logic [2:0] off,
                                                   input logic [1:0] sz);
        logic [BITSIZE-1:0] mask;
        case (sz)
            2'b00:   mask = BITSIZE'(8'hFF);
            2'b01:   mask = BITSIZE'(16'hFFFF);
            default: mask = BITSIZE'(32'hFFFF_FFFF);
        endcase
        mask = mask << {off, 3'b000};
        return (rd & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    assign w_accept  = bus.ReqValid && (r_state == S_IDLE);
    assign w_req_err = f_req_error(bus.ReqWrite, bus.ReqFunct3, bus.ReqAddress);
    assign w_idx     = r_addr[IW+2:3];
    assign w_off     = r_addr[2:0];

    // Control state: FSM, error flag and the captured read doubleword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_rdbuf <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_err <= w_req_err;
            end
            if (r_state == S_READ) begin
                r_rdbuf <= bus.MemReadData;
            end
        end
    end

    // Request payload captured at acceptance; meaningful only while busy.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr   <= bus.ReqAddress[IW+2:0];
            r_funct3 <= bus.ReqFunct3;
            r_write  <= bus.ReqWrite;
            r_wdata  <= bus.ReqStoreData;
        end
    end

    // Next-state and all outputs decoded from the current state.
    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_data  = '0;
        w_resp_error = 1'b0;
        w_mem_addr   = '0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.ReqValid) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (bus.ReqWrite && (bus.ReqFunct3[1:0] == 2'b11)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                w_mem_re   = 1'b1;
                w_mem_addr = w_idx;
                w_next     = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                w_mem_we   = 1'b1;
                w_mem_addr = w_idx;
                w_mem_wdata = (r_funct3[1:0] == 2'b11) ? r_wdata
                            : f_merge(r_rdbuf, r_wdata, w_off, r_funct3[1:0]);
                w_next     = S_RESP;
            end
            default: begin
                w_resp_valid = 1'b1;
                w_resp_error = r_err;
                if (!r_write && !r_err) begin
                    w_resp_data = f_extract(r_rdbuf, w_off, r_funct3);
                end
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.ReqReady       = w_ready;
    assign bus.RespValid      = w_resp_valid;
    assign bus.RespData       = w_resp_data;
    assign bus.RespError      = w_resp_error;
    assign bus.MemoryAddress  = w_mem_addr;
    assign bus.MemReadEnable  = w_mem_re;
    assign bus.MemWriteEnable = w_mem_we;
    assign bus.MemWriteData   = w_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMemory.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [63:0] mem [0:63];

    load_store_if #(.BITSIZE(64), .REGSIZE(64)) bus ();

    load_store_unit #(.BITSIZE(64), .REGSIZE(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DataMemory: combinational read, write at the edge, cleared by reset.
    assign bus.MemReadData = mem[bus.MemoryAddress];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (bus.MemWriteEnable) begin
            mem[bus.MemoryAddress] <= bus.MemWriteData;
        end
    end

    task automatic idle_inputs();
        bus.ReqValid     = 1'b0;
        bus.ReqWrite     = 1'b0;
        bus.ReqFunct3    = 3'b000;
        bus.ReqAddress   = '0;
        bus.ReqStoreData = '0;
    endtask

    // Issue one request from IDLE and observe it until RespValid (bounded).
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] d, output logic [63:0] rdata,
                           output logic rerr, output int lat, output int nrd,
                           output int nwr, output int widx);
        @(negedge clk);
        bus.ReqValid     = 1'b1;
        bus.ReqWrite     = w;
        bus.ReqFunct3    = f3;
        bus.ReqAddress   = a;
        bus.ReqStoreData = d;
        @(posedge clk);
        #1;
        idle_inputs();
        lat = -1; nrd = 0; nwr = 0; widx = -1; rdata = 'x; rerr = 1'bx;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.MemReadEnable) nrd++;
            if (bus.MemWriteEnable) begin
                nwr++;
                widx = int'(bus.MemoryAddress);
            end
            if (bus.RespValid) begin
                lat   = k;
                rdata = bus.RespData;
                rerr  = bus.RespError;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.ReqReady !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ReqReady); end
        n_cmp++; if (bus.RespValid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", bus.RespValid); end
        n_cmp++; if (bus.RespError !== 1'b0) begin n_err++; $display("FAIL reset_rerr got %b want 0", bus.RespError); end
        n_cmp++; if (bus.RespData !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.RespData); end
        n_cmp++; if ({bus.MemReadEnable, bus.MemWriteEnable} !== 2'b00) begin n_err++; $display("FAIL reset_en got %b want 00", {bus.MemReadEnable, bus.MemWriteEnable}); end
        n_cmp++; if (bus.MemoryAddress !== 6'd0) begin n_err++; $display("FAIL reset_maddr got %0d want 0", bus.MemoryAddress); end
        n_cmp++; if (bus.MemWriteData !== 64'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", bus.MemWriteData); end
        rst = 1'b0;
    endtask

    task automatic test_sd_ld();
        logic [63:0] rd; logic re; int lat, nr, nw, wi;
        run_req(1'b1, 3'b011, 64'h18, 64'h1122334455667788, rd, re, lat, nr, nw, wi);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL sd_latency got %0d want 2", lat); end
        n_cmp++; if (nw !== 1 || nr !== 0) begin n_err++; $display("FAIL sd_enables got rd=%0d wr=%0d want rd=0 wr=1", nr, nw); end
        n_cmp++; if (wi !== 3) begin n_err++; $display("FAIL sd_index got %0d want 3", wi); end
        n_cmp++; if (re !== 1'b0 || rd !== 64'h0) begin n_err++; $display("FAIL sd_resp got err=%b data=%h want err=0 data=0", re, rd); end
        n_cmp++; if (mem[3] !== 64'h1122334455667788) begin n_err++; $display("FAIL sd_mem got %h want 1122334455667788", mem[3]); end
        run_req(1'b0, 3'b011, 64'h18, 64'h0, rd, re, lat, nr, nw, wi);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ld_latency got %0d want 2", lat); end
        n_cmp++; if (nr !== 1 || nw !== 0) begin n_err++; $display("FAIL ld_enables got rd=%0d wr=%0d want rd=1 wr=0", nr, nw); end
        n_cmp++; if (rd !== 64'h1122334455667788 || re !== 1'b0) begin n_err++; $display("FAIL ld_data got err=%b data=%h want err=0 data=1122334455667788", re, rd); end
    endtask

    task automatic test_extend();
        logic [63:0] rd; logic re; int lat, nr, nw, wi;
        logic [2:0]  f3_t [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110};
        logic [63:0] ad_t [5] = '{64'h18, 64'h18, 64'h1A, 64'h18, 64'h18};
        logic [63:0] ex_t [5] = '{64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF,
                                  64'hFFFFFFFFFFFF8000, 64'hFFFFFFFF8000F0FF,
                                  64'h000000008000F0FF};
        run_req(1'b1, 3'b011, 64'h18, 64'h000000008000F0FF, rd, re, lat, nr, nw, wi);
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3_t[i], ad_t[i], 64'h0, rd, re, lat, nr, nw, wi);
            n_cmp++; if (rd !== ex_t[i] || re !== 1'b0 || lat !== 2) begin
                n_err++; $display("FAIL extend_%0d got data=%h err=%b lat=%0d want data=%h err=0 lat=2", i, rd, re, lat, ex_t[i]);
            end
        end
    endtask

    task automatic test_rmw();
        logic [63:0] rd; logic re; int lat, nr, nw, wi;
        run_req(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, re, lat, nr, nw, wi);
        run_req(1'b1, 3'b000, 64'h15, 64'h99999999999999AB, rd, re, lat, nr, nw, wi);
        n_cmp++; if (mem[2] !== 64'h1122AB4455667788) begin n_err++; $display("FAIL sb_mem got %h want 1122ab4455667788", mem[2]); end
        n_cmp++; if (lat !== 3 || nr !== 1 || nw !== 1 || wi !== 2) begin n_err++; $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d idx=%0d want 3 1 1 2", lat, nr, nw, wi); end
        n_cmp++; if (re !== 1'b0) begin n_err++; $display("FAIL sb_err got %b want 0", re); end
        run_req(1'b1, 3'b001, 64'h12, 64'h777777777777CDEF, rd, re, lat, nr, nw, wi);
        n_cmp++; if (mem[2] !== 64'h1122AB44CDEF7788) begin n_err++; $display("FAIL sh_mem got %h want 1122ab44cdef7788", mem[2]); end
        n_cmp++; if (lat !== 3 || nr !== 1 || nw !== 1) begin n_err++; $display("FAIL sh_timing got lat=%0d rd=%0d wr=%0d want 3 1 1", lat, nr, nw); end
        run_req(1'b1, 3'b010, 64'h14, 64'h00000000DEADBEEF, rd, re, lat, nr, nw, wi);
        n_cmp++; if (mem[2] !== 64'hDEADBEEFCDEF7788) begin n_err++; $display("FAIL sw_mem got %h want deadbeefcdef7788", mem[2]); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic re; int lat, nr, nw, wi;
        logic        w_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_t [6] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b111};
        logic [63:0] ad_t [6] = '{64'h11, 64'h16, 64'h200, 64'h0, 64'h1F8, 64'h18};
        for (int i = 0; i < 6; i++) begin
            run_req(w_t[i], f3_t[i], ad_t[i], 64'hFFFFFFFFFFFFFFFF, rd, re, lat, nr, nw, wi);
            n_cmp++; if (re !== 1'b1 || rd !== 64'h0 || lat !== 1) begin
                n_err++; $display("FAIL error_%0d got err=%b data=%h lat=%0d want err=1 data=0 lat=1", i, re, rd, lat);
            end
            n_cmp++; if (nr !== 0 || nw !== 0) begin
                n_err++; $display("FAIL error_%0d_mem got rd=%0d wr=%0d want 0 0", i, nr, nw);
            end
        end
        n_cmp++; if (mem[2] !== 64'hDEADBEEFCDEF7788) begin n_err++; $display("FAIL error_mem got %h want deadbeefcdef7788", mem[2]); end
    endtask

    task automatic test_reset_mid();
        int rv;
        @(negedge clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = 3'b010;
        bus.ReqAddress = 64'h20; bus.ReqStoreData = 64'h12345678;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.MemWriteEnable !== 1'b1) begin n_err++; $display("FAIL rstmid_in_write got we=%b want 1", bus.MemWriteEnable); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0 || bus.RespError !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ctrl got rdy=%b rv=%b re=%b want 1 0 0", bus.ReqReady, bus.RespValid, bus.RespError);
        end
        n_cmp++; if ({bus.MemReadEnable, bus.MemWriteEnable} !== 2'b00 || bus.MemoryAddress !== 6'd0 || bus.MemWriteData !== 64'h0 || bus.RespData !== 64'h0) begin
            n_err++; $display("FAIL rstmid_outs got en=%b addr=%0d wd=%h rd=%h want all 0", {bus.MemReadEnable, bus.MemWriteEnable}, bus.MemoryAddress, bus.MemWriteData, bus.RespData);
        end
        rst = 1'b0;
        rv = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.RespValid) rv++;
        end
        n_cmp++; if (rv !== 0) begin n_err++; $display("FAIL rstmid_no_resp got %0d pulses want 0", rv); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic re; int lat, nr, nw, wi;
        int acc [3] = '{-1, -1, -1};
        int rsp [3] = '{-1, -1, -1};
        int na, nrsp;
        run_req(1'b1, 3'b011, 64'h28, 64'hCAFEF00D12345678, rd, re, lat, nr, nw, wi);
        na = 0; nrsp = 0;
        @(negedge clk);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqFunct3 = 3'b011; bus.ReqAddress = 64'h28;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.ReqValid && bus.ReqReady && na < 3) begin acc[na] = c; na++; end
            if (bus.RespValid) begin
                if (nrsp < 3) rsp[nrsp] = c;
                nrsp++;
                n_cmp++; if (bus.RespData !== 64'hCAFEF00D12345678) begin n_err++; $display("FAIL b2b_data got %h want cafef00d12345678", bus.RespData); end
            end
            if (na == 3 && bus.ReqValid) begin
                @(posedge clk);
                #1;
                idle_inputs();
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (acc[i] !== 3 * i) begin n_err++; $display("FAIL b2b_accept_%0d got cycle %0d want %0d", i, acc[i], 3 * i); end
            n_cmp++; if (rsp[i] !== 3 * i + 2) begin n_err++; $display("FAIL b2b_resp_%0d got cycle %0d want %0d", i, rsp[i], 3 * i + 2); end
        end
        n_cmp++; if (nrsp !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", nrsp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sd_ld();
        test_extend();
        test_rmw();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
